dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, cycles from request accept to response; legal range 2..7.
REQ-002 SHALL have parameter DM_BASE, default 32'h0001_0000, byte base address of data memory.
REQ-003 SHALL have parameter DM_WORDS, default 16384, data memory depth in 32-bit words (64 KiB).
REQ-004 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_st_req_addr  in  32  byte address; valid in the accept cycle only.
- store_req_valid  in  1  store request.
- store_req_ready  out  1  store accept.
- store_strb  in  4  active-low byte strobe; 0 = write that byte lane.
- store_data  in  32  lane-aligned write data.
- store_data_valid  out  1  one-cycle store-complete pulse.
- load_req_valid  in  1  load request.
- load_req_ready  out  1  load accept.
- load_data_valid  out  1  one-cycle load-data pulse.
- load_data  out  32  full aligned word read.
- access_err  out  1  one-cycle pulse with a response whose address was out of range.
- sram_ceb  out  1  active-low SRAM chip enable.
- sram_web  out  1  active-low SRAM write enable.
- sram_bweb  out  32  active-low bit write enable.
- sram_addr  out  14  SRAM word address.
- sram_din  out  32  SRAM write data.
- sram_dout  in  32  SRAM read data, valid the cycle after a read with sram_ceb low.

Function
REQ-005 SHALL implement FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE, with exactly one request outstanding.
REQ-006 store_req_ready and load_req_ready SHALL be high only in IDLE.
REQ-007 A request is accepted when valid && ready; if both valids are high, SHALL accept the store and leave load_req_ready low that cycle.
REQ-008 On accept, SHALL latch addr, data, strb and type, and move to ACCESS.
REQ-009 Word address SHALL be (addr - DM_BASE) >> 2, truncated to 14 bits; addr[1:0] SHALL be ignored.
REQ-010 Address is in range iff DM_BASE <= addr < DM_BASE + 4*DM_WORDS, using an unsigned 33-bit compare.
REQ-011 In ACCESS (one cycle), for an in-range load SHALL drive sram_ceb=0, sram_web=1.
REQ-012 In ACCESS, for an in-range store with strb != 4'b1111, SHALL drive sram_ceb=0, sram_web=0, sram_din=data, sram_bweb = strb with each bit replicated 8 times.
REQ-013 In every other cycle and case, SHALL hold sram_ceb=1, sram_web=1, sram_bweb='1.
REQ-014 SHALL register sram_dout on the clock edge ending the cycle after ACCESS; out-of-range loads SHALL capture 32'h0.
REQ-015 WAIT SHALL count so that RESP occurs exactly MEM_LAT+1 cycles after the accept cycle T.
REQ-016 In RESP (one cycle), SHALL pulse load_data_valid with load_data = captured word, or pulse store_data_valid.
REQ-017 In RESP, access_err SHALL pulse if the latched address was out of range.
REQ-018 Out-of-range or all-ones-strobe stores SHALL complete without writing the SRAM.
REQ-019 load_data SHALL hold its last value outside RESP.
REQ-020 Back-to-back throughput SHALL be one request per MEM_LAT+2 cycles.

Reset
REQ-021 rst low SHALL asynchronously force IDLE, both readys=0, all valid pulses=0, access_err=0, load_data=0, sram_ceb=1, sram_web=1, sram_bweb='1, sram_addr=0, sram_din=0.
REQ-022 An in-flight request SHALL be dropped with no response.
REQ-023 Both readys SHALL go high in the first cycle after rst deasserts.

Structure
REQ-024 State enum, DM_BASE, DM_WORDS and the MEM_LAT default SHALL live in shared package dm_pkg.
REQ-025 No sub-module; the SRAM macro is instantiated outside this block.

Verification
REQ-026 Load 0x0001_0010 with MEM_LAT=2 and SRAM word 4 = 0xDEADBEEF, accepted at T -> sram_ceb=0 and sram_addr=4 at T+1; load_data_valid and load_data=0xDEADBEEF at T+3.
REQ-027 Store addr 0x0001_0003, strb 4'b0111, data 0xAB00_0000 -> sram_bweb=0x00FF_FFFF, sram_web=0; store_data_valid at T+3; a read-back of the word changes only byte 3.
REQ-028 Store and load valid in the same cycle -> store accepted first; load accepted in the first IDLE cycle after the store response.
REQ-029 Load 0x0000_0FFC -> no SRAM access; load_data=0, load_data_valid and access_err pulse together at T+3.
REQ-030 rst driven low during WAIT -> immediate IDLE outputs; no response pulse ever follows; both readys high in the first cycle after release.

Source files
------------

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared definitions for the data-memory responder: the FSM state
//               encoding and the default memory map / latency constants.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

  // Default request-accept to response latency, in cycles (legal 2..7).
  localparam int DEF_MEM_LAT = 2;

  // Default byte base address of data memory.
  localparam logic [31:0] DEF_DM_BASE = 32'h0001_0000;

  // Default data memory depth in 32-bit words (64 KiB).
  localparam int DEF_DM_WORDS = 16384;

  // Responder FSM states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Single-outstanding load/store responder in front of a
//               single-port SRAM macro (instantiated outside this block).
//               Each request walks IDLE -> ACCESS -> WAIT -> RESP -> IDLE and
//               is answered MEM_LAT+1 cycles after its accept cycle.
// Ports       : clk, rst (async, active low)
//               ld_st_req_addr                   - request byte address
//               store_req_valid/_ready, store_strb, store_data
//                                                - store request channel
//               load_req_valid/_ready            - load request channel
//               store_data_valid                 - store-complete pulse
//               load_data_valid, load_data       - load response
//               access_err                       - out-of-range response flag
//               sram_ceb/web/bweb/addr/din/dout  - SRAM macro interface
// Revision    : 1.0 - initial release
// ============================================================================
module dm_responder
  import dm_pkg::*;
#(
  parameter int          MEM_LAT  = DEF_MEM_LAT,
  parameter logic [31:0] DM_BASE  = DEF_DM_BASE,
  parameter int          DM_WORDS = DEF_DM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ld_st_req_addr,
  input  logic        store_req_valid,
  output logic        store_req_ready,
  input  logic [3:0]  store_strb,
  input  logic [31:0] store_data,
  output logic        store_data_valid,
  input  logic        load_req_valid,
  output logic        load_req_ready,
  output logic        load_data_valid,
  output logic [31:0] load_data,
  output logic        access_err,
  output logic        sram_ceb,
  output logic        sram_web,
  output logic [31:0] sram_bweb,
  output logic [13:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);

  // WAIT lasts MEM_LAT-1 cycles; the counter starts at MEM_LAT-2 and RESP
  // follows the cycle in which it reads zero.
  localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 2);

  // Unsigned 33-bit window so DM_BASE + size cannot wrap.
  localparam logic [32:0] RANGE_LO = {1'b0, DM_BASE};
  localparam logic [32:0] RANGE_HI = RANGE_LO + (33'(DM_WORDS) << 2);

  state_t      state;
  state_t      next_state;

  logic [13:0] word_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic        is_store_q;
  logic        in_range_q;
  logic [2:0]  wait_cnt;
  logic        first_wait;
  logic [31:0] rdata_q;

  logic        idle_ok;
  logic        store_acc;
  logic        load_acc;
  logic        req_in_range;
  logic [31:0] req_offset;
  logic        do_read;
  logic        do_write;
  logic [31:0] cap_word;
  logic        resp_next;

  // --------------------------------------------------------------------------
  // Request acceptance. Readys are masked by rst so they stay low while the
  // block is held in reset even though the state is already IDLE.
  // --------------------------------------------------------------------------
  assign idle_ok         = (state == S_IDLE) && rst;
  assign store_req_ready = idle_ok;
  // A simultaneous store wins; the load waits for the next IDLE cycle.
  assign load_req_ready  = idle_ok && !store_req_valid;
  assign store_acc       = store_req_valid && store_req_ready;
  assign load_acc        = load_req_valid && load_req_ready;

  assign req_in_range = ({1'b0, ld_st_req_addr} >= RANGE_LO) &&
                        ({1'b0, ld_st_req_addr} <  RANGE_HI);
  assign req_offset   = ld_st_req_addr - DM_BASE;

  // Byte-lane bits and the offset above the 14-bit word index are dropped.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{req_offset[31:16], req_offset[1:0]};

  // --------------------------------------------------------------------------
  // SRAM interface. Only the single ACCESS cycle ever enables the macro.
  // --------------------------------------------------------------------------
  assign do_read  = (state == S_ACCESS) && !is_store_q && in_range_q;
  assign do_write = (state == S_ACCESS) && is_store_q && in_range_q &&
                    (strb_q != 4'b1111);

  assign sram_ceb  = !(do_read || do_write);
  assign sram_web  = !do_write;
  assign sram_bweb = do_write ? {{8{strb_q[3]}}, {8{strb_q[2]}},
                                 {8{strb_q[1]}}, {8{strb_q[0]}}} : '1;
  assign sram_addr = word_q;
  assign sram_din  = data_q;

  // Read data is only valid in the first WAIT cycle; out-of-range or store
  // requests capture zero instead.
  assign cap_word = first_wait ? ((!is_store_q && in_range_q) ? sram_dout : 32'h0)
                               : rdata_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (store_acc || load_acc) next_state = S_ACCESS;
      S_ACCESS: next_state = S_WAIT;
      S_WAIT:   if (wait_cnt == 3'd0) next_state = S_RESP;
      S_RESP:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  assign resp_next = (state == S_WAIT) && (wait_cnt == 3'd0);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      word_q     <= 14'd0;
      data_q     <= 32'h0;
      strb_q     <= 4'b1111;
      is_store_q <= 1'b0;
      in_range_q <= 1'b0;
      wait_cnt   <= 3'd0;
      first_wait <= 1'b0;
      rdata_q    <= 32'h0;
      load_data  <= 32'h0;
    end else begin
      state      <= next_state;
      first_wait <= (state == S_ACCESS);

      if (store_acc || load_acc) begin
        word_q     <= req_offset[15:2];
        data_q     <= store_data;
        strb_q     <= store_strb;
        is_store_q <= store_acc;
        in_range_q <= req_in_range;
      end

      if (state == S_ACCESS) begin
        wait_cnt <= WAIT_INIT;
      end else if ((state == S_WAIT) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end

      if (first_wait) begin
        rdata_q <= cap_word;
      end

      // load_data moves only on entry to RESP so it holds between responses;
      // with MEM_LAT=2 the capture and the RESP entry share one edge.
      if (resp_next && !is_store_q) begin
        load_data <= cap_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response pulses
  // --------------------------------------------------------------------------
  assign load_data_valid  = (state == S_RESP) && !is_store_q;
  assign store_data_valid = (state == S_RESP) && is_store_q;
  assign access_err       = (state == S_RESP) && !in_range_q;

endmodule : dm_responder
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_responder
// Description : Scoreboard bench for dm_responder with a behavioural SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ld_st_req_addr;
  logic        store_req_valid;
  logic        store_req_ready;
  logic [3:0]  store_strb;
  logic [31:0] store_data;
  logic        store_data_valid;
  logic        load_req_valid;
  logic        load_req_ready;
  logic        load_data_valid;
  logic [31:0] load_data;
  logic        access_err;
  logic        sram_ceb;
  logic        sram_web;
  logic [31:0] sram_bweb;
  logic [13:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  always #5 clk = ~clk;

  dm_responder #(.MEM_LAT(LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .ld_st_req_addr   (ld_st_req_addr),
    .store_req_valid  (store_req_valid),
    .store_req_ready  (store_req_ready),
    .store_strb       (store_strb),
    .store_data       (store_data),
    .store_data_valid (store_data_valid),
    .load_req_valid   (load_req_valid),
    .load_req_ready   (load_req_ready),
    .load_data_valid  (load_data_valid),
    .load_data        (load_data),
    .access_err       (access_err),
    .sram_ceb         (sram_ceb),
    .sram_web         (sram_web),
    .sram_bweb        (sram_bweb),
    .sram_addr        (sram_addr),
    .sram_din         (sram_din),
    .sram_dout        (sram_dout)
  );

  // Behavioural single-port SRAM; a few words are preloaded while in reset.
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (!rst) begin
      mem[0]     <= 32'h5566_7788;
      mem[4]     <= 32'hDEAD_BEEF;
      mem[16383] <= 32'h1234_5678;
    end else if (!sram_ceb) begin
      if (!sram_web) mem[sram_addr] <= (mem[sram_addr] & sram_bweb) | (sram_din & ~sram_bweb);
      else           sram_dout <= mem[sram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    bit          err;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (load_data_valid || store_data_valid || access_err)) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_resp: ldv=%b stv=%b err=%b with empty scoreboard", load_data_valid, store_data_valid, access_err);
      end else begin
        e = q.pop_front();
        check("resp_load_valid", {31'b0, load_data_valid}, {31'b0, e.is_load});
        check("resp_store_valid", {31'b0, store_data_valid}, {31'b0, !e.is_load});
        if (e.is_load) check("load_data", load_data, e.data);
        check("access_err", {31'b0, access_err}, {31'b0, e.err});
        check("resp_cycle", cyc, e.at);
      end
    end
  end

  task automatic idle_inputs();
    store_req_valid = 1'b0;
    load_req_valid  = 1'b0;
    ld_st_req_addr  = 32'hFFFF_FFF0;
    store_strb      = 4'b1111;
    store_data      = 32'h0;
  endtask

  // Issue one request; returns in the ACCESS cycle (#1 after the accept edge).
  task automatic do_req(input bit st, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic [31:0] exp_data,
                        input bit exp_err, input bit expect_resp, output int t);
    int n;
    n = 0;
    @(negedge clk);
    ld_st_req_addr  = addr;
    store_req_valid = st;
    load_req_valid  = !st;
    store_strb      = strb;
    store_data      = data;
    #1;
    while (!(st ? store_req_ready : load_req_ready) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: request addr %h never accepted", addr);
      idle_inputs();
      t = -1;
    end else begin
      t = cyc;
      if (expect_resp) q.push_back('{!st, exp_data, exp_err, cyc + LAT + 1});
      @(posedge clk);
      #1;
      idle_inputs();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
  endtask

  int t, ts, tl, n;

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    // Reset state
    check("rst_store_ready", {31'b0, store_req_ready}, 32'd0);
    check("rst_load_ready", {31'b0, load_req_ready}, 32'd0);
    check("rst_ceb", {31'b0, sram_ceb}, 32'd1);
    check("rst_web", {31'b0, sram_web}, 32'd1);
    check("rst_bweb", sram_bweb, 32'hFFFF_FFFF);
    check("rst_addr", {18'b0, sram_addr}, 32'd0);
    check("rst_din", sram_din, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_pulses", {29'b0, load_data_valid, store_data_valid, access_err}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_rst", {30'b0, store_req_ready, load_req_ready}, 32'd3);

    // Aligned load of word 4
    do_req(1'b0, 32'h0001_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, t);
    check("load_ceb_T1", {31'b0, sram_ceb}, 32'd0);
    check("load_web_T1", {31'b0, sram_web}, 32'd1);
    check("load_addr_T1", {18'b0, sram_addr}, 32'd4);

    // Single-byte store to lane 3 of word 0, then read back
    do_req(1'b1, 32'h0001_0003, 4'b0111, 32'hAB00_0000, 32'h0, 1'b0, 1'b1, t);
    check("store_ceb_T1", {31'b0, sram_ceb}, 32'd0);
    check("store_web_T1", {31'b0, sram_web}, 32'd0);
    check("store_bweb_T1", sram_bweb, 32'h00FF_FFFF);
    check("store_din_T1", sram_din, 32'hAB00_0000);
    check("store_addr_T1", {18'b0, sram_addr}, 32'd0);
    do_req(1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'hAB66_7788, 1'b0, 1'b1, t);

    // Simultaneous store and load: store first, load in first IDLE after
    @(negedge clk);
    ld_st_req_addr  = 32'h0001_0018;
    store_req_valid = 1'b1;
    load_req_valid  = 1'b1;
    store_strb      = 4'b0000;
    store_data      = 32'hCAFE_F00D;
    n = 0;
    #1;
    while (!store_req_ready && n < 50) begin @(negedge clk); #1; n++; end
    check("both_store_ready", {31'b0, store_req_ready}, 32'd1);
    check("both_load_ready", {31'b0, load_req_ready}, 32'd0);
    ts = cyc;
    q.push_back('{1'b0, 32'h0, 1'b0, cyc + LAT + 1});
    @(posedge clk);
    #1;
    store_req_valid = 1'b0;
    n = 0;
    while (!load_req_ready && n < 50) begin @(negedge clk); #1; n++; end
    tl = cyc;
    check("load_after_store_cycle", tl - ts, LAT + 2);
    q.push_back('{1'b1, 32'hCAFE_F00D, 1'b0, cyc + LAT + 1});
    @(posedge clk);
    #1;
    idle_inputs();

    // Out-of-range load below the window
    do_req(1'b0, 32'h0000_0FFC, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1, t);
    check("oor_load_ceb_T1", {31'b0, sram_ceb}, 32'd1);
    // Store exactly one past the top of the window
    do_req(1'b1, 32'h0002_0000, 4'b0000, 32'h1111_1111, 32'h0, 1'b1, 1'b1, t);
    check("oor_store_ceb_T1", {31'b0, sram_ceb}, 32'd1);
    // Last in-range word, lower half-word store then unaligned read-back
    do_req(1'b1, 32'h0001_FFFC, 4'b1100, 32'h0000_BEEF, 32'h0, 1'b0, 1'b1, t);
    check("top_store_addr_T1", {18'b0, sram_addr}, 32'h3FFF);
    do_req(1'b0, 32'h0001_FFFE, 4'hF, 32'h0, 32'h1234_BEEF, 1'b0, 1'b1, t);
    // All-ones strobe store completes without a write
    do_req(1'b1, 32'h0001_0010, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, t);
    check("noop_store_ceb_T1", {31'b0, sram_ceb}, 32'd1);
    do_req(1'b0, 32'h0001_0011, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, t);
    drain();

    // load_data holds its value across a store response
    do_req(1'b1, 32'h0001_0020, 4'b0000, 32'h7777_7777, 32'h0, 1'b0, 1'b1, t);
    drain();
    check("load_data_hold", load_data, 32'hDEAD_BEEF);

    // Reset while in WAIT drops the request
    do_req(1'b0, 32'h0001_0010, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, t);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_ready", {30'b0, store_req_ready, load_req_ready}, 32'd0);
    check("midrst_ceb_web", {30'b0, sram_ceb, sram_web}, 32'd3);
    check("midrst_bweb", sram_bweb, 32'hFFFF_FFFF);
    check("midrst_addr", {18'b0, sram_addr}, 32'd0);
    check("midrst_load_data", load_data, 32'd0);
    check("midrst_pulses", {29'b0, load_data_valid, store_data_valid, access_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_midrst", {30'b0, store_req_ready, load_req_ready}, 32'd3);
    repeat (LAT + 6) @(negedge clk);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_dm_responder
`default_nettype wire
